// File: rtl/synth_pkg.sv
// Shared definitions for the voice table.
//   NOTE_W / VEL_W : MIDI note and velocity widths.
//   voice_rec_t    : one voice slot {gate, trig, note, velocity}.
//   scan_state_e   : scan sequencer states.
package synth_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  typedef struct packed {
    logic              gate;
    logic              trig;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  velocity;
  } voice_rec_t;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/note_phase_rom.sv
// MIDI note -> oscillator phase-increment lookup.
// The 128-entry table is built at elaboration from equal temperament
// (A4 = note 69 = 440 Hz), rounded to nearest and saturated to PHASE_W bits.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en         : lookup enable; when low the output register loads zero
//   note       : table address (MIDI note number)
//   phase_inc  : registered table value, one cycle after note/en
module note_phase_rom
  import synth_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int FS_HZ   = 48000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NOTE_W-1:0]  note,
  output logic [PHASE_W-1:0] phase_inc
);

  // 2^(1/12): one semitone.
  localparam real SEMI = 1.0594630943592953;

  function automatic logic [PHASE_W-1:0] calc_inc(input int n);
    real                f;
    real                scale;
    real                r;
    longint unsigned    acc;
    f = 440.0;
    if (n >= 69) begin
      for (int k = 69; k < n; k++) f = f * SEMI;
    end else begin
      for (int k = n; k < 69; k++) f = f / SEMI;
    end
    scale = 1.0;
    for (int k = 0; k < PHASE_W; k++) scale = scale * 2.0;
    r = (f * scale / real'(FS_HZ)) + 0.5;
    if (r >= scale) begin
      acc = '1;
    end else if (r >= 2147483648.0) begin
      // $rtoi is 32-bit signed; split off the top bit for 32-bit increments.
      acc = 64'd2147483648 + 64'($rtoi(r - 2147483648.0));
    end else begin
      acc = 64'($rtoi(r));
    end
    return acc[PHASE_W-1:0];
  endfunction

  logic [PHASE_W-1:0] tbl [128];

  for (genvar i = 0; i < 128; i++) begin : g_tbl
    localparam logic [PHASE_W-1:0] INC = calc_inc(i);
    assign tbl[i] = INC;
  end

  logic [PHASE_W-1:0] phase_d, phase_q;

  always_comb begin
    phase_d = en ? tbl[note] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  assign phase_inc = phase_q;

endmodule

// File: rtl/voice_table.sv
// Polyphonic voice table with a continuous round-robin scan.
// Note events from the SPI decoder update per-voice records; a scan
// sequencer streams every record, with its phase increment, to the
// synthesis engine one voice per cycle.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   evt_ready                     : level flag, rising edge = one note message
//   evt_note_on/voice/note/velocity : event fields, captured with the edge
//   scan_valid/voice/gate/trig/note/velocity/phase_inc : scan record stream
//   active_count                  : number of gated voices
//   err_voice                     : one-cycle pulse, event to nonexistent voice
module voice_table
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int PHASE_W    = 24,
  parameter int FS_HZ      = 48000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              evt_ready,
  input  logic                              evt_note_on,
  input  logic [7:0]                        evt_voice,
  input  logic [6:0]                        evt_note,
  input  logic [6:0]                        evt_velocity,
  output logic                              scan_valid,
  output logic [$clog2(NUM_VOICES)-1:0]     scan_voice,
  output logic                              scan_gate,
  output logic                              scan_trig,
  output logic [6:0]                        scan_note,
  output logic [6:0]                        scan_velocity,
  output logic [PHASE_W-1:0]                scan_phase_inc,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
  output logic                              err_voice
);

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int CNT_W   = $clog2(NUM_VOICES + 1);

  logic               evt_ready_d, evt_ready_q;
  logic               accept, voice_ok, new_gate;
  logic [VOICE_W-1:0] wr_idx;
  logic               err_d, err_q;

  voice_rec_t         table_d [NUM_VOICES];
  voice_rec_t         table_q [NUM_VOICES];
  logic [CNT_W-1:0]   count_d, count_q;

  scan_state_e        state_d, state_q;
  logic [VOICE_W-1:0] scan_idx_d, scan_idx_q;

  voice_rec_t         rec_p1_d, rec_p1_q, rec_p2_d, rec_p2_q;
  logic [VOICE_W-1:0] voice_p1_d, voice_p1_q, voice_p2_d, voice_p2_q;
  logic               vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic [PHASE_W-1:0] phase_p2;

  // Event detect: one accepted event per rising edge of evt_ready.
  always_comb begin
    evt_ready_d = evt_ready;
    accept      = evt_ready & ~evt_ready_q;
    voice_ok    = ({1'b0, evt_voice} < 9'(NUM_VOICES));
    wr_idx      = evt_voice[VOICE_W-1:0];
    // A note-on with zero velocity is a note-off.
    new_gate    = evt_note_on & (evt_velocity != '0);
    err_d       = accept & ~voice_ok;
  end

  // Table update. The scan's trig-clear is applied first so that a
  // note-on write to the same voice in the same cycle overrides it.
  always_comb begin
    table_d = table_q;
    count_d = count_q;
    if (state_q == SCAN_RUN) table_d[scan_idx_q].trig = 1'b0;
    if (accept && voice_ok) begin
      if (new_gate) begin
        table_d[wr_idx].gate     = 1'b1;
        table_d[wr_idx].trig     = 1'b1;
        table_d[wr_idx].note     = evt_note;
        table_d[wr_idx].velocity = evt_velocity;
      end else begin
        table_d[wr_idx].gate     = 1'b0;
      end
      if (new_gate && !table_q[wr_idx].gate)      count_d = count_q + CNT_W'(1);
      else if (!new_gate && table_q[wr_idx].gate) count_d = count_q - CNT_W'(1);
    end
  end

  // Scan sequencer: one idle cycle after reset, then free-running.
  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    case (state_q)
      SCAN_IDLE: state_d = SCAN_RUN;
      SCAN_RUN:  scan_idx_d = (scan_idx_q == VOICE_W'(NUM_VOICES - 1)) ?
                              '0 : scan_idx_q + VOICE_W'(1);
      default:   state_d = SCAN_IDLE;
    endcase
  end

  // Stage 1: read the record at the scan index (pre-write value).
  // Stage 2: record delayed to line up with the ROM's registered output.
  always_comb begin
    vld_p1_d   = (state_q == SCAN_RUN);
    rec_p1_d   = vld_p1_d ? table_q[scan_idx_q] : '0;
    voice_p1_d = vld_p1_d ? scan_idx_q : '0;
    vld_p2_d   = vld_p1_q;
    rec_p2_d   = rec_p1_q;
    voice_p2_d = voice_p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_ready_q <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      state_q     <= SCAN_IDLE;
      scan_idx_q  <= '0;
      vld_p1_q    <= 1'b0;
      rec_p1_q    <= '0;
      voice_p1_q  <= '0;
      vld_p2_q    <= 1'b0;
      rec_p2_q    <= '0;
      voice_p2_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) table_q[i] <= '0;
    end else begin
      evt_ready_q <= evt_ready_d;
      err_q       <= err_d;
      count_q     <= count_d;
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      vld_p1_q    <= vld_p1_d;
      rec_p1_q    <= rec_p1_d;
      voice_p1_q  <= voice_p1_d;
      vld_p2_q    <= vld_p2_d;
      rec_p2_q    <= rec_p2_d;
      voice_p2_q  <= voice_p2_d;
      table_q     <= table_d;
    end
  end

  note_phase_rom #(
    .PHASE_W (PHASE_W),
    .FS_HZ   (FS_HZ)
  ) u_rom (
    .clk       (clk),
    .reset     (reset),
    .en        (vld_p1_q),
    .note      (rec_p1_q.note),
    .phase_inc (phase_p2)
  );

  assign scan_valid     = vld_p2_q;
  assign scan_voice     = voice_p2_q;
  assign scan_gate      = rec_p2_q.gate;
  assign scan_trig      = rec_p2_q.trig;
  assign scan_note      = rec_p2_q.note;
  assign scan_velocity  = rec_p2_q.velocity;
  assign scan_phase_inc = phase_p2;
  assign active_count   = count_q;
  assign err_voice      = err_q;

endmodule

// File: tb/tb_voice_table.sv
module tb_voice_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        evt_ready;
  logic        evt_note_on;
  logic [7:0]  evt_voice;
  logic [6:0]  evt_note;
  logic [6:0]  evt_velocity;
  logic        scan_valid;
  logic [3:0]  scan_voice;
  logic        scan_gate;
  logic        scan_trig;
  logic [6:0]  scan_note;
  logic [6:0]  scan_velocity;
  logic [23:0] scan_phase_inc;
  logic [4:0]  active_count;
  logic        err_voice;

  voice_table dut (
    .clk            (clk),
    .reset          (reset),
    .evt_ready      (evt_ready),
    .evt_note_on    (evt_note_on),
    .evt_voice      (evt_voice),
    .evt_note       (evt_note),
    .evt_velocity   (evt_velocity),
    .scan_valid     (scan_valid),
    .scan_voice     (scan_voice),
    .scan_gate      (scan_gate),
    .scan_trig      (scan_trig),
    .scan_note      (scan_note),
    .scan_velocity  (scan_velocity),
    .scan_phase_inc (scan_phase_inc),
    .active_count   (active_count),
    .err_voice      (err_voice)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int    voice;
    bit    gate;
    bit    trig;
    int    note;
    int    vel;
    int    inc;
    bit    chk_inc;
    string tag;
  } sb_t;

  sb_t sb_q[$];

  // Highest active_count seen while enabled.
  logic       mon_en = 1'b0;
  logic [4:0] max_cnt;
  always @(negedge clk) begin
    if (!mon_en)                     max_cnt <= '0;
    else if (active_count > max_cnt) max_cnt <= active_count;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_evt(input bit on, input int v, input int n, input int vel);
    evt_note_on  = on;
    evt_voice    = 8'(v);
    evt_note     = 7'(n);
    evt_velocity = 7'(vel);
    evt_ready    = 1'b1;
    step();
    evt_ready    = 1'b0;
  endtask

  function automatic void push_rec(input string tag, input int v, input bit g, input bit t,
                                   input int n, input int vel, input int inc, input bit ci);
    sb_t e;
    e.voice = v; e.gate = g; e.trig = t; e.note = n; e.vel = vel;
    e.inc = inc; e.chk_inc = ci; e.tag = tag;
    sb_q.push_back(e);
  endfunction

  // Pop the oldest expectation and compare it with the next scan of that voice.
  task automatic check_scan();
    sb_t e;
    bit  found;
    e = sb_q.pop_front();
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (scan_valid === 1'b1 && 32'(scan_voice) == e.voice) begin
        found = 1'b1;
        chk({e.tag, "_gate"}, 32'(scan_gate), 32'(e.gate));
        chk({e.tag, "_trig"}, 32'(scan_trig), 32'(e.trig));
        chk({e.tag, "_note"}, 32'(scan_note), 32'(e.note));
        chk({e.tag, "_vel"},  32'(scan_velocity), 32'(e.vel));
        if (e.chk_inc) chk({e.tag, "_inc"}, 32'(scan_phase_inc), 32'(e.inc));
      end
    end
    chk({e.tag, "_seen"}, 32'(found), 32'd1);
  endtask

  // Called just after a posedge with reset still high: release it and
  // confirm scan_valid comes back exactly 3 cycles later starting at voice 0.
  task automatic release_check(input string tag);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_valid_low"}, 32'(scan_valid), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_valid_high"}, 32'(scan_valid), 32'd1);
    chk({tag, "_first_voice"}, 32'(scan_voice), 32'd0);
    step();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(scan_valid), 32'd0);
    chk({tag, "_count"}, 32'(active_count), 32'd0);
    chk({tag, "_err"},   32'(err_voice), 32'd0);
    chk({tag, "_inc"},   32'(scan_phase_inc), 32'd0);
    chk({tag, "_rec"},   32'({scan_gate, scan_trig, scan_note, scan_velocity}), 32'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; evt_ready = 1'b0; evt_note_on = 1'b0;
    evt_voice = '0; evt_note = '0; evt_velocity = '0;

    // Power-up reset
    for (int i = 0; i < 4; i++) step();
    check_zero_outputs("rst0");
    release_check("rel0");

    // Note-on voice 3 A4
    send_evt(1'b1, 3, 69, 100);
    step(); step();
    chk("on3_count", 32'(active_count), 32'd1);
    push_rec("on3_first", 3, 1'b1, 1'b1, 69, 100, 153791, 1'b1);
    push_rec("on3_second", 3, 1'b1, 1'b0, 69, 100, 153791, 1'b1);
    check_scan();
    check_scan();

    // Velocity-0 note-on releases voice 3, keeping note and velocity
    send_evt(1'b1, 3, 69, 0);
    step(); step();
    chk("off3_count", 32'(active_count), 32'd0);
    push_rec("off3", 3, 1'b0, 1'b0, 69, 100, 153791, 1'b1);
    check_scan();

    // Out-of-range voice: one-cycle error pulse, nothing written
    send_evt(1'b1, 20, 60, 50);
    chk("err_pulse_hi", 32'(err_voice), 32'd1);
    step();
    chk("err_pulse_lo", 32'(err_voice), 32'd0);
    step();
    chk("err_count", 32'(active_count), 32'd0);
    push_rec("err_v4", 4, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    check_scan();

    // evt_ready held high 50 cycles: only the first message is taken
    evt_note_on = 1'b1; evt_voice = 8'd7; evt_note = 7'd81; evt_velocity = 7'd10;
    evt_ready = 1'b1;
    step();
    evt_voice = 8'd8; evt_note = 7'd57; evt_velocity = 7'd20;
    for (int i = 0; i < 49; i++) step();
    evt_ready = 1'b0;
    step(); step();
    chk("hold_count", 32'(active_count), 32'd1);
    push_rec("hold_v7", 7, 1'b1, 1'b0, 81, 10, 307582, 1'b1);
    push_rec("hold_v8", 8, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    check_scan();
    check_scan();

    // Note-off to an ungated voice leaves the count alone
    send_evt(1'b0, 8, 57, 20);
    step(); step();
    chk("offidle_count", 32'(active_count), 32'd1);

    // Write to voice 5 in the same cycle as its stage-1 read
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (scan_valid === 1'b1 && scan_voice == 4'd2) seen = 1'b1;
    end
    chk("collide_sync", 32'(seen), 32'd1);
    step();
    push_rec("collide_old", 5, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    push_rec("collide_new", 5, 1'b1, 1'b1, 57, 33, 76896, 1'b1);
    send_evt(1'b1, 5, 57, 33);
    check_scan();
    check_scan();
    chk("collide_count", 32'(active_count), 32'd2);

    // Reset, then retrigger a gated voice and reset again mid-scan
    reset = 1'b1;
    step();
    check_zero_outputs("rst1");
    step();
    release_check("rel1");
    mon_en = 1'b1;
    send_evt(1'b1, 9, 60, 50);
    step(); step();
    chk("retrig_count1", 32'(active_count), 32'd1);
    send_evt(1'b1, 9, 69, 90);
    step(); step();
    chk("retrig_count2", 32'(active_count), 32'd1);
    push_rec("retrig_v9", 9, 1'b1, 1'b1, 69, 90, 153791, 1'b1);
    check_scan();
    for (int i = 0; i < 5; i++) step();
    chk("retrig_max", 32'(max_cnt), 32'd1);
    mon_en = 1'b0;
    reset = 1'b1;
    step();
    check_zero_outputs("rst2");
    step();
    release_check("rel2");
    chk("rst2_count_after", 32'(active_count), 32'd0);
    for (int v = 0; v < 16; v++) push_rec($sformatf("clear_v%0d", v), v, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    for (int v = 0; v < 16; v++) check_scan();

    // evt_ready already high as reset deasserts: accepted immediately
    evt_note_on = 1'b1; evt_voice = 8'd2; evt_note = 7'd69; evt_velocity = 7'd1;
    evt_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    release_check("rel3");
    chk("early_count", 32'(active_count), 32'd1);
    push_rec("early_v2", 2, 1'b1, 1'b1, 69, 1, 153791, 1'b1);
    check_scan();
    evt_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
